// File: rtl/u_dmem_if.sv
// Core-side data-memory bus: byte address, per-lane write/read enables, write data,
// registered read data and the sticky access-error flag.
interface u_dmem_if;
    logic [15:0] dat_a;
    logic [3:0]  dat_we;
    logic [31:0] dat_wd;
    logic [3:0]  dat_re;
    logic [31:0] dat_rd;
    logic        dat_err;

    modport master (
        output dat_a, dat_we, dat_wd, dat_re,
        input  dat_rd, dat_err
    );

    modport slave (
        input  dat_a, dat_we, dat_wd, dat_re,
        output dat_rd, dat_err
    );
endinterface

// File: rtl/u_dmem.sv
// Zero-stall data memory with a one-entry pending-store register and read forwarding.
// Optional feature macro: DMEM_ERR_EN enables the sticky dat_err access-error flag.
module u_dmem #(
    parameter int DEPTH = 4096
) (
    input  logic     clk,
    input  logic     rst,
    u_dmem_if.slave  bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [14:0] DEPTH_W = 15'(DEPTH);

    logic [31:0] r_mem [DEPTH];

    logic        r_pv;
    logic [13:0] r_pidx;
    logic [3:0]  r_pmask;
    logic [31:0] r_pdata;
    logic [31:0] r_rd;

    logic [13:0]   w_idx;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] w_paddr;
    logic          w_in_range;
    logic          w_wr;
    logic          w_rd;
    logic          w_fwd_hit;
    logic [31:0]   w_arr_word;
    logic [31:0]   w_rd_data;

    assign w_idx      = bus.dat_a[15:2];
    assign w_addr     = w_idx[AW-1:0];
    assign w_paddr    = r_pidx[AW-1:0];
    assign w_in_range = ({1'b0, w_idx} < DEPTH_W);
    assign w_wr       = |bus.dat_we;
    assign w_rd       = |bus.dat_re;
    assign w_fwd_hit  = r_pv && (r_pidx == w_idx);

    // Array lookup for the requested word; out-of-range words read as zero.
    always_comb begin
        w_arr_word = 32'h0000_0000;
        if (w_in_range) begin
            w_arr_word = r_mem[w_addr];
        end else begin
            w_arr_word = 32'h0000_0000;
        end
    end

    // Per-lane merge: the uncommitted store wins over the array for its enabled lanes.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            if (bus.dat_re[k] && w_in_range) begin
                if (w_fwd_hit && r_pmask[k]) begin
                    w_rd_data[8*k +: 8] = r_pdata[8*k +: 8];
                end else begin
                    w_rd_data[8*k +: 8] = w_arr_word[8*k +: 8];
                end
            end else begin
                w_rd_data[8*k +: 8] = 8'h00;
            end
        end
    end

    // Commit the pending store one cycle after capture; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (r_pv) begin
            for (int k = 0; k < 4; k++) begin
                if (r_pmask[k]) begin
                    r_mem[w_paddr][8*k +: 8] <= r_pdata[8*k +: 8];
                end
            end
        end
    end

    // Pending-store capture and registered read data; reset drops any uncommitted store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv    <= 1'b0;
            r_pidx  <= 14'h0000;
            r_pmask <= 4'h0;
            r_pdata <= 32'h0000_0000;
            r_rd    <= 32'h0000_0000;
        end else begin
            if (w_wr && w_in_range) begin
                r_pv    <= 1'b1;
                r_pidx  <= w_idx;
                r_pmask <= bus.dat_we;
                r_pdata <= bus.dat_wd;
            end else begin
                r_pv    <= 1'b0;
            end
            // A simultaneous write takes priority; the read is dropped and dat_rd holds.
            if (w_rd && !w_wr) begin
                r_rd <= w_rd_data;
            end
        end
    end

    assign bus.dat_rd = r_rd;

`ifdef DMEM_ERR_EN
    logic r_err;

    // Sticky flag for out-of-range accesses and read/write collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (((w_wr || w_rd) && !w_in_range) || (w_wr && w_rd)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.dat_err = r_err;
`else
    assign bus.dat_err = 1'b0;
`endif

endmodule

// File: tb/tb_u_dmem.sv
// Directed self-checking bench for u_dmem (DEPTH=4096); dat_err expectation follows DMEM_ERR_EN.
module tb_u_dmem;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

`ifdef DMEM_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    u_dmem_if bus ();

    u_dmem #(.DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_idle();
        bus.dat_we = 4'h0;
        bus.dat_re = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd);
        bus.dat_a  = a;
        bus.dat_we = we;
        bus.dat_wd = wd;
        bus.dat_re = 4'h0;
        @(posedge clk);
        #1;
        bus.dat_we = 4'h0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [3:0] re);
        bus.dat_a  = a;
        bus.dat_we = 4'h0;
        bus.dat_re = re;
        @(posedge clk);
        #1;
        bus.dat_re = 4'h0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.dat_a  = 16'h0000;
        bus.dat_we = 4'h0;
        bus.dat_wd = 32'h0000_0000;
        bus.dat_re = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.dat_rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_rd: got %h exp %h", bus.dat_rd, 32'h0000_0000);
        end
        checks++;
        if (bus.dat_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b exp %b", bus.dat_err, 1'b0);
        end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        do_write(16'h0010, 4'hF, 32'hDEAD_BEEF);
        do_read(16'h0010, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fwd_full: got %h exp %h", bus.dat_rd, 32'hDEAD_BEEF);
        end
        do_idle();
        do_read(16'h0013, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL array_low_bits_ignored: got %h exp %h", bus.dat_rd, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_partial_write();
        do_write(16'h0020, 4'hF, 32'h1122_3344);
        do_idle();
        do_write(16'h0020, 4'b0100, 32'h00AA_0000);
        do_idle();
        do_read(16'h0020, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h11AA_3344) begin
            errors++;
            $display("FAIL partial_commit: got %h exp %h", bus.dat_rd, 32'h11AA_3344);
        end
        do_write(16'h0020, 4'b0001, 32'h0000_00FF);
        do_read(16'h0020, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h11AA_33FF) begin
            errors++;
            $display("FAIL partial_forward_merge: got %h exp %h", bus.dat_rd, 32'h11AA_33FF);
        end
        do_idle();
        do_read(16'h0020, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h11AA_33FF) begin
            errors++;
            $display("FAIL partial_after_commit: got %h exp %h", bus.dat_rd, 32'h11AA_33FF);
        end
    endtask

    task automatic test_lane_read();
        do_write(16'h0030, 4'hF, 32'hCAFE_BABE);
        do_idle();
        do_read(16'h0030, 4'b0011);
        checks++;
        if (bus.dat_rd !== 32'h0000_BABE) begin
            errors++;
            $display("FAIL lane_read_low: got %h exp %h", bus.dat_rd, 32'h0000_BABE);
        end
        do_idle();
        checks++;
        if (bus.dat_rd !== 32'h0000_BABE) begin
            errors++;
            $display("FAIL lane_read_hold: got %h exp %h", bus.dat_rd, 32'h0000_BABE);
        end
        do_read(16'h0030, 4'b1100);
        checks++;
        if (bus.dat_rd !== 32'hCAFE_0000) begin
            errors++;
            $display("FAIL lane_read_high: got %h exp %h", bus.dat_rd, 32'hCAFE_0000);
        end
    endtask

    task automatic test_back_to_back();
        do_write(16'h0050, 4'hF, 32'hA5A5_A5A5);
        do_write(16'h0054, 4'hF, 32'h5A5A_5A5A);
        do_write(16'h0058, 4'hF, 32'h0102_0304);
        do_read(16'h0058, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h0102_0304) begin
            errors++;
            $display("FAIL b2b_fwd_last: got %h exp %h", bus.dat_rd, 32'h0102_0304);
        end
        do_read(16'h0050, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL b2b_first: got %h exp %h", bus.dat_rd, 32'hA5A5_A5A5);
        end
        do_read(16'h0054, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL b2b_second: got %h exp %h", bus.dat_rd, 32'h5A5A_5A5A);
        end
    endtask

    task automatic test_reset_discard();
        do_write(16'h0040, 4'hF, 32'h0BAD_F00D);
        do_idle();
        do_read(16'h0040, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rstd_preload: got %h exp %h", bus.dat_rd, 32'h0BAD_F00D);
        end
        do_write(16'h0040, 4'hF, 32'h1234_5678);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dat_rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL rstd_rd_async: got %h exp %h", bus.dat_rd, 32'h0000_0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.dat_rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL rstd_rd_held: got %h exp %h", bus.dat_rd, 32'h0000_0000);
        end
        rst = 1'b0;
        do_read(16'h0040, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rstd_discarded: got %h exp %h", bus.dat_rd, 32'h0BAD_F00D);
        end
    endtask

    task automatic test_out_of_range();
        do_read(16'h0010, 4'hF);
        checks++;
        if (bus.dat_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_err_before: got %b exp %b", bus.dat_err, 1'b0);
        end
        do_read(16'h4000, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL oor_read_zero: got %h exp %h", bus.dat_rd, 32'h0000_0000);
        end
        checks++;
        if (bus.dat_err !== EXP_ERR) begin
            errors++;
            $display("FAIL oor_err_set: got %b exp %b", bus.dat_err, EXP_ERR);
        end
        do_write(16'h4010, 4'hF, 32'hFFFF_FFFF);
        do_idle();
        do_idle();
        checks++;
        if (bus.dat_err !== EXP_ERR) begin
            errors++;
            $display("FAIL oor_err_sticky: got %b exp %b", bus.dat_err, EXP_ERR);
        end
        do_read(16'h0010, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL oor_write_dropped: got %h exp %h", bus.dat_rd, 32'hDEAD_BEEF);
        end
        do_read(16'hFFFC, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h0000_0000) begin
            errors++;
            $display("FAIL oor_top_zero: got %h exp %h", bus.dat_rd, 32'h0000_0000);
        end
    endtask

    task automatic test_collision();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.dat_err !== 1'b0) begin
            errors++;
            $display("FAIL coll_err_cleared: got %b exp %b", bus.dat_err, 1'b0);
        end
        do_read(16'h0010, 4'hF);
        bus.dat_a  = 16'h0060;
        bus.dat_we = 4'hF;
        bus.dat_wd = 32'h7777_7777;
        bus.dat_re = 4'hF;
        @(posedge clk);
        #1;
        bus.dat_we = 4'h0;
        bus.dat_re = 4'h0;
        checks++;
        if (bus.dat_rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL coll_rd_held: got %h exp %h", bus.dat_rd, 32'hDEAD_BEEF);
        end
        checks++;
        if (bus.dat_err !== EXP_ERR) begin
            errors++;
            $display("FAIL coll_err: got %b exp %b", bus.dat_err, EXP_ERR);
        end
        do_idle();
        do_read(16'h0060, 4'hF);
        checks++;
        if (bus.dat_rd !== 32'h7777_7777) begin
            errors++;
            $display("FAIL coll_write_done: got %h exp %h", bus.dat_rd, 32'h7777_7777);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_forward();
        test_partial_write();
        test_lane_read();
        test_back_to_back();
        test_reset_discard();
        test_out_of_range();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/u_dmem.md
U_DMEM -- requirements
Module: u_dmem

Interface
REQ-001 Parameter: DEPTH, default 4096, number of 32-bit words in the data array; legal range 1..16384.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous assertion, active-high.
REQ-004 Port: dat_a  input  16  byte address from core; word index = dat_a[15:2]; dat_a[1:0] ignored.
REQ-005 Port: dat_we  input  4  per-byte-lane write enables; nonzero = write request this cycle.
REQ-006 Port: dat_wd  input  32  write data, lane-aligned (lane k = bits 8k+7:8k).
REQ-007 Port: dat_re  input  4  per-byte-lane read enables; nonzero = read request this cycle.
REQ-008 Port: dat_rd  output  32  registered read data, lane-aligned.
REQ-009 Port: dat_err  output  1  sticky access-error flag (see Configuration).

Function
REQ-010 The block SHALL respond to every request with no stall/back-pressure; one request per cycle max.
REQ-011 A read issued in cycle N SHALL present data on dat_rd in cycle N+1; lanes with dat_re[k]=0 SHALL read as 0x00.
REQ-012 dat_rd SHALL hold its last value in cycles following no read request.
REQ-013 A write issued in cycle N SHALL be captured into a one-entry pending-store register (valid, word index, lane mask, data) at the end of N and committed to the array at the end of N+1.
REQ-014 Back-to-back writes SHALL be sustained: the entry captured at end of N commits while the write of N+1 is captured at the same edge.
REQ-015 Reads SHALL merge the pending entry: per lane k, if pending valid, index equal and mask[k]=1, return pending data lane k, else array lane k.
REQ-016 Read-after-write to the same word in consecutive cycles SHALL return the newly written lanes and unmodified old lanes.
REQ-017 Lanes with dat_we[k]=0 SHALL leave the stored byte unchanged.
REQ-018 Word index >= DEPTH: writes SHALL be dropped (no pending capture), reads SHALL return 0x00000000.
REQ-019 dat_we and dat_re both nonzero in one cycle: the write SHALL be performed, the read ignored, dat_rd held.
REQ-020 Pending entry with no new write SHALL clear its valid bit after commit.

Reset
REQ-021 Assertion of rst SHALL immediately force dat_rd=0, pending valid=0, dat_err=0.
REQ-022 A write captured but not yet committed when rst asserts SHALL be discarded; array contents SHALL NOT be reset.
REQ-023 The first request SHALL be accepted in the first clk edge after rst deasserts.

Configuration
REQ-024 Macro DMEM_ERR_EN defined: dat_err SHALL set at the end of any cycle with an out-of-range access (REQ-018) or read/write collision (REQ-019) and stay set until rst.
REQ-025 Macro DMEM_ERR_EN undefined: dat_err SHALL be constant 0 and no error logic SHALL be synthesised; all other behaviour identical.

Verification
REQ-026 Write 0xDEADBEEF, we=4'hF to 0x0010 in cycle N; read re=4'hF to 0x0010 in N+1 -> dat_rd=0xDEADBEEF in N+2 (forwarding path).
REQ-027 Preload word 0x0020 = 0x11223344; write we=4'b0100, wd=0x00AA0000; read re=4'hF two cycles later -> 0x11AA3344.
REQ-028 Read 0x0030 with re=4'b0011 where word=0xCAFEBABE -> dat_rd=0x0000BABE; idle following cycle -> dat_rd stays 0x0000BABE.
REQ-029 Write 0x12345678 to 0x0040, assert rst in cycle N+1 before commit, release, read 0x0040 -> prior contents returned, dat_rd=0 during reset.
REQ-030 DEPTH=4096, with DMEM_ERR_EN: read address 0x4000 -> dat_rd=0, dat_err=1 next cycle and held; without macro -> dat_err=0.
